// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIR output stream.
//   SAMPLE_W / FIR_ERR_W : sample and Avalon-ST error widths from variable_saturation
//   fir_sample_t         : one stored stream beat, {err, data}
//   ERR_*                : Avalon-ST error tag encodings carried with each sample
package fir_stream_pkg;
   localparam int SAMPLE_W  = 12;
   localparam int FIR_ERR_W = 2;

   typedef struct packed {
      logic [FIR_ERR_W-1:0] err;
      logic [SAMPLE_W-1:0]  data;
   } fir_sample_t;

   localparam logic [FIR_ERR_W-1:0] ERR_NONE     = 2'b00;
   localparam logic [FIR_ERR_W-1:0] ERR_SAT_POS  = 2'b01;
   localparam logic [FIR_ERR_W-1:0] ERR_SAT_NEG  = 2'b10;
   localparam logic [FIR_ERR_W-1:0] ERR_INVALID  = 2'b11;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : clear to zero (an increment in the same cycle yields 1)
//   i_inc      : increment, holds at all-ones
//   o_cnt      : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (i_clr)
         // increment beats clear: the event being counted is not lost
         r_cnt <= i_inc ? W'(1) : '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/ast_sample_fifo.sv
// Flop-based output FIFO behind variable_saturation. The upstream source is
// valid-only, so a push while full (with no pop) drops the sample and is
// reported via a sticky overflow flag and a saturating drop counter.
//   ast_sink_*     : valid-only Avalon-ST sink (data, error, valid)
//   ast_source_*   : Avalon-ST source with ready backpressure
//   fill_level     : number of stored entries
//   overflow       : sticky drop flag, cleared by overflow_clr
//   overflow_clr   : clears overflow and drop_count (a same-cycle drop wins)
//   drop_count     : saturating count of dropped samples
module ast_sample_fifo
   import fir_stream_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int ERR_W  = FIR_ERR_W,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        ast_sink_data,
   input  logic [ERR_W-1:0]         ast_sink_error,
   input  logic                     ast_sink_valid,
   output logic [DATA_W-1:0]        ast_source_data,
   output logic [ERR_W-1:0]         ast_source_error,
   output logic                     ast_source_valid,
   input  logic                     ast_source_ready,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     overflow,
   input  logic                     overflow_clr,
   output logic [CNT_W-1:0]         drop_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [ERR_W-1:0]  err;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [LVL_W-1:0]   r_fill;
   logic               r_overflow;

   logic               w_valid;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   entry_t             w_head;

   assign w_valid = (r_fill != '0);
   assign w_full  = (r_fill == LVL_W'(DEPTH));
   assign w_pop   = w_valid & ast_source_ready;
   // a pop frees the slot in the same cycle, so full+pop still accepts
   assign w_push  = ast_sink_valid & (~w_full | w_pop);
   assign w_drop  = ast_sink_valid & w_full & ~w_pop;

   // storage is not reset; only the pointers and level define contents
   always_ff @(posedge clk) begin
      if (w_push && !reset)
         r_mem[r_wr_ptr] <= '{err: ast_sink_error, data: ast_sink_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)
            r_fill <= r_fill + LVL_W'(1);
         else if (w_pop && !w_push)
            r_fill <= r_fill - LVL_W'(1);
         if (w_drop)
            r_overflow <= 1'b1;
         else if (overflow_clr)
            r_overflow <= 1'b0;
      end
   end

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (overflow_clr),
      .i_inc (w_drop),
      .o_cnt (drop_count)
   );

   assign w_head           = r_mem[r_rd_ptr];
   assign ast_source_data  = w_head.data;
   assign ast_source_error = w_head.err;
   assign ast_source_valid = w_valid;
   assign fill_level       = r_fill;
   assign overflow         = r_overflow;
endmodule
